// File: rtl/servgrid_qmon.sv
// rtl/servgrid_qmon.sv - per-tile toggle counters, rise-pending interrupts and a Wishbone register window
//
// Watches the q outputs of a grid of servant tiles. Every tile has a
// saturating toggle counter and a pending bit that sets on a rising edge.
// The pending bits, gated by a mask, form a registered interrupt.
//
// Optional feature macro: SERVGRID_QMON_SYNC_EN
//   defined   : i_q passes through a two-flop synchronizer before sampling
//   undefined : i_q is sampled directly (it is synchronous to wb_clk)
//
// Ports:
//   wb_clk    - single clock, rising edge
//   wb_rst    - synchronous active-high reset
//   i_q       - grid q outputs, bit t = tile t (row*ncol+col)
//   i_wb_adr  - byte address, bits [8:2] select the word
//   i_wb_dat  - write data, bits above NTILE ignored
//   i_wb_sel  - byte select, ignored (writes are full-word)
//   i_wb_we   - write enable
//   i_wb_stb  - cycle request
//   o_wb_rdt  - read data, non-zero only while o_wb_ack is high
//   o_wb_ack  - single-cycle acknowledge
//   o_irq     - registered OR of pending & mask
//
// Register map (word offset):
//   0..NTILE-1 COUNT[t]  read: counter, write: clear
//   0x40       STATUS    read-only sampled q
//   0x41       PENDING   write-1-to-clear
//   0x42       MASK      read/write

module servgrid_qmon #(
  parameter int NTILE = 16,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [NTILE-1:0] i_q,
  input  logic [31:0]      i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  output logic             o_irq
);

  localparam logic [6:0]       OFF_STATUS  = 7'h40;
  localparam logic [6:0]       OFF_PENDING = 7'h41;
  localparam logic [6:0]       OFF_MASK    = 7'h42;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Number of edges after reset before both q_s and q_d hold real samples.
  // Each synchronizer stage adds one more edge to wait for.
`ifdef SERVGRID_QMON_SYNC_EN
  localparam int FILL_N = 4;
`else
  localparam int FILL_N = 2;
`endif

  logic [NTILE-1:0] q_s_q, q_s_d;
  logic [NTILE-1:0] q_d_q, q_d_d;
  logic [FILL_N-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q [NTILE];
  logic [CNT_W-1:0] cnt_d [NTILE];
  logic [NTILE-1:0] pend_q, pend_d;
  logic [NTILE-1:0] mask_q, mask_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             ack_q, ack_d;
  logic             irq_q, irq_d;

  logic             primed;
  logic [6:0]       off;
  logic             req;
  logic             wr;
  logic [NTILE-1:0] wdat;
  logic [NTILE-1:0] tog;
  logic [NTILE-1:0] rise;
  logic [NTILE-1:0] w1c;
  logic [31:0]      rd;

  logic unused_bits;
  assign unused_bits = ^{i_wb_sel, i_wb_adr, i_wb_dat};

`ifdef SERVGRID_QMON_SYNC_EN
  logic [NTILE-1:0] sync1_q, sync1_d;
  logic [NTILE-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_q;
    sync2_d = sync1_q;
    q_s_d   = sync2_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  always_comb begin
    q_s_d = i_q;
  end
`endif

  // A one shifts through fill_q once per edge after reset; the top bit is
  // the primed flag, so the reset-zero contents of q_s/q_d never count.
  assign primed = fill_q[FILL_N-1];

  always_comb begin
    q_d_d  = q_s_q;
    fill_d = {fill_q[FILL_N-2:0], 1'b1};

    off  = i_wb_adr[8:2];
    // A request is accepted only while no ack is showing, which spaces
    // acks apart when stb is held.
    req  = i_wb_stb & ~ack_q;
    wr   = req & i_wb_we;
    wdat = i_wb_dat[NTILE-1:0];

    tog  = primed ? (q_s_q ^ q_d_q) : '0;
    rise = primed ? (q_s_q & ~q_d_q) : '0;

    rd = '0;
    for (int t = 0; t < NTILE; t++) begin
      if (off == 7'(t)) begin
        rd = 32'(cnt_q[t]);
      end
    end
    case (off)
      OFF_STATUS:  rd = 32'(q_s_q);
      OFF_PENDING: rd = 32'(pend_q);
      OFF_MASK:    rd = 32'(mask_q);
      default:     ;
    endcase

    // Clear takes priority over a simultaneous toggle.
    for (int t = 0; t < NTILE; t++) begin
      cnt_d[t] = cnt_q[t];
      if (wr && (off == 7'(t))) begin
        cnt_d[t] = '0;
      end else if (tog[t] && (cnt_q[t] != CNT_MAX)) begin
        cnt_d[t] = cnt_q[t] + CNT_W'(1);
      end
    end

    // Rise is OR'd in after the clear so a coincident rise survives.
    w1c    = (wr && (off == OFF_PENDING)) ? wdat : '0;
    pend_d = (pend_q & ~w1c) | rise;
    mask_d = (wr && (off == OFF_MASK)) ? wdat : mask_q;

    irq_d = |(pend_q & mask_q);
    ack_d = req;
    rdt_d = req ? rd : '0;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      q_s_q  <= '0;
      q_d_q  <= '0;
      fill_q <= '0;
      for (int t = 0; t < NTILE; t++) begin
        cnt_q[t] <= '0;
      end
      pend_q <= '0;
      mask_q <= '0;
      rdt_q  <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      q_s_q  <= q_s_d;
      q_d_q  <= q_d_d;
      fill_q <= fill_d;
      for (int t = 0; t < NTILE; t++) begin
        cnt_q[t] <= cnt_d[t];
      end
      pend_q <= pend_d;
      mask_q <= mask_d;
      rdt_q  <= rdt_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_servgrid_qmon.sv
// tb/tb_servgrid_qmon.sv - scoreboard bench for servgrid_qmon with a sample-history reference model

module tb_servgrid_qmon;

  localparam int NT   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          wb_clk;
  logic          wb_rst;
  logic [NT-1:0] i_q;
  logic [31:0]   i_wb_adr;
  logic [31:0]   i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic          i_wb_we;
  logic          i_wb_stb;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack;
  logic          o_irq;

  servgrid_qmon #(.NTILE(NT), .CNT_W(CW)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .i_q      (i_q),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_sel (i_wb_sel),
    .i_wb_we  (i_wb_we),
    .i_wb_stb (i_wb_stb),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_irq    (o_irq)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int checks    = 0;
  int failures  = 0;
  int ack_count = 0;
  bit mon_en    = 1'b0;

  // Reference state: sample history of i_q as seen at each edge after reset.
  int unsigned   m_cnt [NT];
  logic [NT-1:0] m_pend, m_mask;
  logic [NT-1:0] m_s1, m_s2;
  int            m_nsamp;
  bit            m_ack, m_irq;
  logic [31:0]   exp_q [$];

  logic [6:0]    m_off;
  bit            m_req, m_wr;
  logic [NT-1:0] m_wd, m_tog, m_rise;

  function automatic logic [31:0] model_read(input logic [6:0] off);
    logic [31:0] r;
    r = '0;
    for (int t = 0; t < NT; t++) begin
      if (int'(off) == t) r = m_cnt[t];
    end
    if (off == 7'h40) r = 32'(m_s1);
    if (off == 7'h41) r = 32'(m_pend);
    if (off == 7'h42) r = 32'(m_mask);
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge wb_clk);
      if (wb_rst) begin
        for (int t = 0; t < NT; t++) m_cnt[t] = 0;
        m_pend = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
        m_nsamp = 0; m_ack = 0; m_irq = 0;
      end else begin
        m_off = i_wb_adr[8:2];
        m_req = i_wb_stb && !m_ack;
        m_wr  = m_req && i_wb_we;
        m_wd  = i_wb_dat[NT-1:0];
        // Edges count only once two post-reset samples exist.
        if (m_nsamp >= 2) begin
          m_tog  = m_s1 ^ m_s2;
          m_rise = m_s1 & ~m_s2;
        end else begin
          m_tog  = '0;
          m_rise = '0;
        end
        m_irq = ((m_pend & m_mask) != 0);
        if (m_req) exp_q.push_back(model_read(m_off));
        for (int t = 0; t < NT; t++) begin
          if (m_wr && int'(m_off) == t) m_cnt[t] = 0;
          else if (m_tog[t] && m_cnt[t] < CMAX) m_cnt[t] = m_cnt[t] + 1;
        end
        if (m_wr && m_off == 7'h41) m_pend = m_pend & ~m_wd;
        m_pend = m_pend | m_rise;
        if (m_wr && m_off == 7'h42) m_mask = m_wd;
        m_ack = m_req;
        m_s2 = m_s1;
        m_s1 = i_q;
        if (m_nsamp < 2) m_nsamp++;
      end
    end
  end

  // Monitor: compares every cycle's outputs against the model.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge wb_clk);
      if (mon_en) begin
        if (o_wb_ack) ack_count++;
        checks++;
        if (o_wb_ack !== m_ack) begin
          failures++;
          $display("FAIL ack t=%0t got %b expected %b", $time, o_wb_ack, m_ack);
        end
        if (m_ack) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t got rdt %0h expected an entry", $time, o_wb_rdt);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (o_wb_rdt !== e) begin
              failures++;
              $display("FAIL rdt t=%0t got %0h expected %0h", $time, o_wb_rdt, e);
            end
          end
        end else begin
          checks++;
          if (o_wb_rdt !== 32'h0) begin
            failures++;
            $display("FAIL rdt_idle t=%0t got %0h expected 0", $time, o_wb_rdt);
          end
        end
        checks++;
        if (o_irq !== m_irq) begin
          failures++;
          $display("FAIL irq t=%0t got %b expected %b", $time, o_irq, m_irq);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  // Holds stb for n edges; for n=1 rd is the data shown with the ack.
  task automatic bus(input logic [6:0] off, input bit we, input logic [31:0] d,
                     input int n, output logic [31:0] rd);
    @(negedge wb_clk);
    i_wb_stb = 1'b1;
    i_wb_we  = we;
    i_wb_adr = $urandom;
    i_wb_adr[8:2] = off;
    i_wb_dat = d;
    i_wb_sel = 4'($urandom);
    repeat (n) @(negedge wb_clk);
    rd = o_wb_rdt;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic do_reset(input logic [NT-1:0] v);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    i_wb_stb = 1'b0;
    repeat (3) begin
      i_q = NT'($urandom);
      @(negedge wb_clk);
    end
    i_q = v;
    @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  function automatic logic [6:0] rand_off();
    case ($urandom_range(0, 6))
      0, 1:    return 7'($urandom_range(0, NT - 1));
      2:       return 7'h40;
      3:       return 7'h41;
      4:       return 7'h42;
      5:       return 7'($urandom_range(16, 31));
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    int a0;
    int b;
    wb_rst = 1'b1; i_q = '0; i_wb_adr = '0; i_wb_dat = '0;
    i_wb_sel = '0; i_wb_we = 1'b0; i_wb_stb = 1'b0;
    idle(2);
    mon_en = 1'b1;
    chk("reset_ack", 32'(o_wb_ack), 32'h0);
    chk("reset_irq", 32'(o_irq), 32'h0);
    chk("reset_rdt", o_wb_rdt, 32'h0);

    // All-ones held across reset release: nothing counted.
    do_reset(16'hFFFF);
    idle(4);
    for (int t = 0; t < NT; t++) bus(7'(t), 1'b0, 32'h0, 1, rd);
    bus(7'h03, 1'b0, 32'h0, 1, rd); chk("hold_count3", rd, 32'h0);
    bus(7'h41, 1'b0, 32'h0, 1, rd); chk("hold_pending", rd, 32'h0);
    bus(7'h40, 1'b0, 32'h0, 1, rd); chk("hold_status", rd, 32'hFFFF);

    // Five toggles on tile 3.
    do_reset('0);
    idle(3);
    repeat (5) begin
      @(negedge wb_clk); i_q[3] = ~i_q[3];
      idle(2);
    end
    idle(2);
    for (int t = 0; t < NT; t++) bus(7'(t), 1'b0, 32'h0, 1, rd);
    bus(7'h03, 1'b0, 32'h0, 1, rd); chk("tog5_count3", rd, 32'd5);
    bus(7'h02, 1'b0, 32'h0, 1, rd); chk("tog5_count2", rd, 32'd0);
    bus(7'h41, 1'b0, 32'h0, 1, rd); chk("tog5_pending", rd, 32'h0008);

    // Saturation: 20 toggles with a 4-bit counter.
    do_reset('0);
    idle(3);
    repeat (20) begin
      @(negedge wb_clk); i_q[0] = ~i_q[0];
    end
    idle(3);
    bus(7'h00, 1'b0, 32'h0, 1, rd); chk("sat_count0", rd, 32'd15);

    // Masked interrupt raise and W1C drop.
    do_reset('0);
    idle(3);
    bus(7'h42, 1'b1, 32'hFFFF_0008, 1, rd);
    bus(7'h42, 1'b0, 32'h0, 1, rd); chk("mask_rd", rd, 32'h0008);
    @(negedge wb_clk); i_q[3] = 1'b1;
    idle(4);
    chk("irq_set", 32'(o_irq), 32'h1);
    bus(7'h41, 1'b1, 32'h0000_0008, 1, rd);
    idle(1);
    chk("irq_clear", 32'(o_irq), 32'h0);

    // Clear vs toggle on tile 2, then W1C vs rise on bit 2.
    do_reset('0);
    idle(3);
    @(negedge wb_clk); i_q[2] = 1'b1;
    bus(7'h02, 1'b1, 32'hDEAD_BEEF, 1, rd);
    idle(2);
    bus(7'h02, 1'b0, 32'h0, 1, rd); chk("clear_wins", rd, 32'h0);
    @(negedge wb_clk); i_q[2] = 1'b0;
    idle(3);
    @(negedge wb_clk); i_q[2] = 1'b1;
    bus(7'h41, 1'b1, 32'h0000_0004, 1, rd);
    idle(2);
    bus(7'h41, 1'b0, 32'h0, 1, rd); chk("set_wins", rd, 32'h0004);

    // Request during reset is dropped.
    @(negedge wb_clk);
    wb_rst = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h0000_0104;
    @(negedge wb_clk);
    i_wb_stb = 1'b0;
    chk("rst_req_noack", 32'(o_wb_ack), 32'h0);
    @(negedge wb_clk);
    wb_rst = 1'b0;

    // Held stb: six edges give three acks; unmapped read is zero.
    idle(3);
    a0 = ack_count;
    bus(7'h00, 1'b0, 32'h0, 6, rd);
    idle(2);
    chk("held_stb_acks", 32'(ack_count - a0), 32'd3);
    a0 = ack_count;
    bus(7'h50, 1'b0, 32'h0, 1, rd);
    chk("unmapped_rd", rd, 32'h0);
    idle(1);
    chk("unmapped_ack", 32'(ack_count - a0), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset(NT'($urandom));
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          b = $urandom_range(0, NT - 1);
          i_q[b] = ~i_q[b];
        end
        if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        else bus(rand_off(), 1'($urandom), $urandom,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(2, 5) : 1, rd);
      end
    end

    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servgrid_qmon.md
SERVGRID_QMON -- requirements
Module: servgrid_qmon

Interface
REQ-001 The block SHALL have parameter NTILE, default 16, meaning the number of servant tiles monitored (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the per-tile toggle counter width (1..32).
REQ-003 Port wb_clk, input, 1, SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port wb_rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port i_q, input, NTILE, SHALL carry the grid q outputs; bit t is tile t (row*ncol+col).
REQ-006 Port i_wb_adr, input, 32, SHALL be the Wishbone byte address; only bits [8:2] are decoded.
REQ-007 Port i_wb_dat, input, 32, SHALL be the Wishbone write data.
REQ-008 Port i_wb_sel, input, 4, SHALL be the byte select; it is ignored and all writes are full-word.
REQ-009 Port i_wb_we, input, 1, SHALL be the write enable.
REQ-010 Port i_wb_stb, input, 1, SHALL be the strobe (cycle request).
REQ-011 Port o_wb_rdt, output, 32, SHALL be the read data, valid when o_wb_ack=1.
REQ-012 Port o_wb_ack, output, 1, SHALL be the single-cycle acknowledge.
REQ-013 Port o_irq, output, 1, SHALL be the OR of (pending & mask).

Function
REQ-014 The block SHALL register i_q into q_s each cycle and hold the previous q_s in q_d; toggle[t] = q_s[t]^q_d[t], rise[t] = q_s[t]&~q_d[t].
REQ-015 The block SHALL use a primed flag, cleared by reset and set one cycle after the first q_s load; no toggle or rise is counted while primed=0.
REQ-016 Latency: an i_q change at edge N SHALL be visible in the counter and pending bit after edge N+2.
REQ-017 Counter t SHALL increment by 1 on toggle[t] and saturate at 2^CNT_W-1, never wrapping.
REQ-018 pending[t] SHALL set on rise[t] and be independent of the mask.
REQ-019 Register map (word offset = adr[8:2]):
- 0..NTILE-1: COUNT[t], zero-extended on read; any write clears it.
- 0x40: STATUS, reads q_s, read-only.
- 0x41: PENDING, write-1-to-clear.
- 0x42: MASK, read/write, NTILE bits.
- Unmapped offsets read 0 and ignore writes.
REQ-020 Handshake: o_wb_ack SHALL pulse high exactly one cycle after any cycle with i_wb_stb=1 and o_wb_ack=0, and never two consecutive cycles; a held stb yields one ack every second cycle.
REQ-021 Writes SHALL take effect on the same edge that asserts o_wb_ack; o_wb_rdt SHALL be loaded on that edge and zero on non-ack cycles.
REQ-022 If a COUNT clear coincides with a toggle on that tile, the clear SHALL win (result 0).
REQ-023 If a PENDING W1C coincides with a rise on that bit, the set SHALL win (bit stays 1).
REQ-024 o_irq SHALL be registered, updating one cycle after pending or mask changes.
REQ-025 Bits of i_wb_dat above NTILE SHALL be ignored; read bits above NTILE/CNT_W SHALL be 0.

Reset
REQ-026 When wb_rst=1 at an edge, the block SHALL zero q_s, q_d, primed, all counters, pending, mask, o_wb_rdt, o_wb_ack and o_irq.
REQ-027 A bus request presented during reset SHALL be dropped with no ack; reset mid-transaction SHALL cancel any pending ack.
REQ-028 Edges on i_q during reset, and on the first cycle after release, SHALL NOT be counted.

Configuration
REQ-029 With SERVGRID_QMON_SYNC_EN defined, i_q SHALL pass through a two-flop synchronizer (reset to 0) before q_s, giving a latency of N+4, and primed SHALL wait until the synchronizer is filled.
REQ-030 Without SERVGRID_QMON_SYNC_EN, i_q SHALL be sampled directly into q_s, since it is synchronous to wb_clk.

Verification
REQ-031 Reset release with i_q=0xFFFF held SHALL leave COUNT[*]=0 and PENDING=0 and give STATUS=0xFFFF.
REQ-032 Toggling i_q[3] five times SHALL give COUNT[3]=5, PENDING=0x0008 and COUNT[others]=0.
REQ-033 With CNT_W=4 and 20 toggles on tile 0, COUNT[0] SHALL read 15.
REQ-034 MASK=0x0008 plus a rise on tile 3 SHALL raise o_irq; a write of 0x0008 to PENDING SHALL then drop o_irq one cycle later.
REQ-035 A write to COUNT[2] coinciding with a toggle on tile 2 SHALL read back 0; a W1C of PENDING bit 2 coinciding with a rise SHALL read back 1.
REQ-036 stb held for 6 cycles SHALL produce exactly 3 acks; a read of offset 0x50 SHALL return 0 with an ack.
